// File: rtl/mlp_pkg.sv
// Shared fixed-point constants, FSM state encodings and the output
// shift/saturate/ReLU step used by every MLP layer sequencer.
package mlp_pkg;

    localparam int MLP_DW   = 16;
    localparam int MLP_FRAC = 8;
    localparam int MLP_ACCW = 40;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BIAS  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic signed [MLP_ACCW-1:0] SAT_HI =
        {{(MLP_ACCW-MLP_DW+1){1'b0}}, {(MLP_DW-1){1'b1}}};
    localparam logic signed [MLP_ACCW-1:0] SAT_LO = ~SAT_HI;

    // Drop the fraction (floor), clamp to the DW-bit signed range, then optionally ReLU.
    function automatic logic [MLP_DW-1:0] sat_relu(
        input logic signed [MLP_ACCW-1:0] acc,
        input logic                       relu
    );
        logic signed [MLP_ACCW-1:0] r;
        logic [MLP_DW-1:0]          y;
        r = acc >>> MLP_FRAC;
        if (r > SAT_HI) begin
            y = SAT_HI[MLP_DW-1:0];
        end else if (r < SAT_LO) begin
            y = SAT_LO[MLP_DW-1:0];
        end else begin
            y = r[MLP_DW-1:0];
        end
        if (relu && (r < 0)) begin
            y = '0;
        end
        return y;
    endfunction

endpackage

// File: rtl/mlp_mac.sv
// Signed multiply-accumulate register: clear, load a bias aligned to the
// fixed point, or add a full-width weight*activation product.
module mlp_mac #(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load_bias,
    input  logic            acc_en,
    input  logic [DW-1:0]   bias,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;

    assign prod = $signed(a) * $signed(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= {{(ACCW-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
        end else if (acc_en) begin
            acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        end
    end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Sequences one fully-connected layer: per neuron load bias, stream N_IN
// weight/activation pairs through the MAC, emit one saturated output word.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 10,
    parameter int DW    = MLP_DW,
    parameter int FRAC  = MLP_FRAC,
    parameter int ACCW  = MLP_ACCW,
    parameter int RELU  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [3:0]                      bias_addr,
    input  logic [DW-1:0]                   bias_data,
    output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
    input  logic [DW-1:0]                   w_data,
    output logic [$clog2(N_IN)-1:0]         x_addr,
    input  logic [DW-1:0]                   x_data,
    output logic                            y_valid,
    output logic [3:0]                      y_idx,
    output logic [DW-1:0]                   y_data,
    output logic [2:0]                      dbg_state
);

    localparam int         XAW     = $clog2(N_IN);
    localparam int         WAW     = $clog2(N_IN*N_OUT);
    localparam logic [XAW-1:0] IN_LAST  = XAW'(N_IN - 1);
    localparam logic [3:0]     OUT_LAST = 4'(N_OUT - 1);
    localparam logic       RELU_EN = (RELU != 0);

    logic [2:0]      state;
    logic [3:0]      neuron;
    logic [XAW-1:0]  in_cnt;
    logic [WAW-1:0]  w_cnt;
    logic [ACCW-1:0] acc;

    // Handshake: start is only looked at in IDLE (no queuing); busy covers
    // BIAS..WRITE; done is a one-cycle strobe following the DONE state.
    assign busy      = (state == ST_BIAS) || (state == ST_MAC) || (state == ST_WRITE);
    assign dbg_state = state;

    // Address buses are forced to 0 outside the states that use them.
    assign bias_addr = (state == ST_BIAS) ? neuron : 4'd0;
    assign w_addr    = (state == ST_MAC)  ? w_cnt  : '0;
    assign x_addr    = (state == ST_MAC)  ? in_cnt : '0;

    mlp_mac #(
        .DW   (DW),
        .FRAC (FRAC),
        .ACCW (ACCW)
    ) u_mac (
        .clk       (clk),
        .rst       (reset),
        .clr       (state == ST_IDLE),
        .load_bias (state == ST_BIAS),
        .acc_en    (state == ST_MAC),
        .bias      (bias_data),
        .a         (w_data),
        .b         (x_data),
        .acc       (acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            neuron  <= 4'd0;
            in_cnt  <= '0;
            w_cnt   <= '0;
            y_valid <= 1'b0;
            y_idx   <= 4'd0;
            y_data  <= '0;
            done    <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_BIAS;
                        neuron <= 4'd0;
                        w_cnt  <= '0;
                    end
                end
                ST_BIAS: begin
                    in_cnt <= '0;
                    state  <= ST_MAC;
                end
                ST_MAC: begin
                    // w_cnt runs continuously across neurons, tracking neuron*N_IN+input.
                    w_cnt  <= w_cnt + WAW'(1);
                    in_cnt <= in_cnt + XAW'(1);
                    if (in_cnt == IN_LAST) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    y_valid <= 1'b1;
                    y_idx   <= neuron;
                    y_data  <= sat_relu(acc, RELU_EN);
                    if (neuron == OUT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        neuron <= neuron + 4'd1;
                        state  <= ST_BIAS;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: a ReLU and a linear instance share memories,
// start and reset; outputs are scoreboarded and control/address buses checked every cycle.
module tb_mlp_layer_sequencer;

    localparam int W = 20;
    localparam logic [2:0] S_IDLE = 3'd0, S_BIAS = 3'd1, S_MAC = 3'd2, S_WRITE = 3'd3, S_DONE = 3'd4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    int   cyc = 0;

    logic [15:0] bias_mem [16];
    logic [15:0] w_mem    [256];
    logic [15:0] x_mem    [16];

    logic        busy0, done0, yv0, busy1, done1, yv1;
    logic [3:0]  ba0, ba1, yi0, yi1, xa0, xa1;
    logic [7:0]  wa0, wa1;
    logic [15:0] bd0, bd1, wd0, wd1, xd0, xd1, yd0, yd1;
    logic [2:0]  st0, st1;

    assign bd0 = bias_mem[ba0];
    assign wd0 = w_mem[wa0];
    assign xd0 = x_mem[xa0];
    assign bd1 = bias_mem[ba1];
    assign wd1 = w_mem[wa1];
    assign xd1 = x_mem[xa1];

    mlp_layer_sequencer #(.N_IN(16), .N_OUT(10), .RELU(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
        .bias_addr(ba0), .bias_data(bd0), .w_addr(wa0), .w_data(wd0),
        .x_addr(xa0), .x_data(xd0), .y_valid(yv0), .y_idx(yi0), .y_data(yd0),
        .dbg_state(st0)
    );

    mlp_layer_sequencer #(.N_IN(16), .N_OUT(10), .RELU(0)) u_dut_lin (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
        .bias_addr(ba1), .bias_data(bd1), .w_addr(wa1), .w_data(wd1),
        .x_addr(xa1), .x_data(xd1), .y_valid(yv1), .y_idx(yi1), .y_data(yd1),
        .dbg_state(st1)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bias_base, bias_step, w_val, x_val;
        logic [15:0] relu_base, relu_step, lin_base, lin_step;
    } vec_t;

    vec_t vecs [6];
    vec_t cur;
    bit   use_table;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_lin_q[$];

    int checks = 0;
    int failures = 0;
    int base = 0;
    bit active = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, expv, cyc);
        end
    endtask

    function automatic logic [15:0] model_y(input int n, input bit relu);
        longint a, r;
        a = longint'($signed(bias_mem[n])) * 256;
        for (int i = 0; i < 16; i++) begin
            a += longint'($signed(w_mem[n*16+i])) * longint'($signed(x_mem[i]));
        end
        r = a >>> 8;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    function automatic logic [21:0] exp_ctrl(input int rel, input bit act);
        logic [2:0] st;
        logic b, d, v;
        logic [3:0] ba, xa;
        logic [7:0] wa;
        int n, p;
        st = S_IDLE; b = 0; d = 0; v = 0; ba = 0; wa = 0; xa = 0;
        if (act && rel >= 0 && rel < 180) begin
            n = rel / 18;
            p = rel % 18;
            b = 1;
            v = (p == 0 && n > 0);
            if (p == 0) begin
                st = S_BIAS; ba = 4'(n);
            end else if (p <= 16) begin
                st = S_MAC; wa = 8'(n*16 + p - 1); xa = 4'(p - 1);
            end else begin
                st = S_WRITE;
            end
        end else if (act && rel == 180) begin
            st = S_DONE; v = 1;
        end else if (act && rel == 181) begin
            d = 1;
        end
        return {st, b, d, v, ba, wa, xa};
    endfunction

    task automatic push_run();
        logic [15:0] er, el;
        er = cur.relu_base;
        el = cur.lin_base;
        for (int n = 0; n < 10; n++) begin
            if (use_table) begin
                exp_q.push_back({4'(n), er});
                exp_lin_q.push_back({4'(n), el});
                er = er + cur.relu_step;
                el = el + cur.lin_step;
            end else begin
                exp_q.push_back({4'(n), model_y(n, 1'b1)});
                exp_lin_q.push_back({4'(n), model_y(n, 1'b0)});
            end
        end
    endtask

    // One clock: account for a start the DUT will accept, then check at the falling edge.
    task automatic tick();
        logic [21:0] e;
        logic [W-1:0] q;
        if (start && !reset && (!active || (cyc - base) >= 181)) begin
            base = cyc + 1;
            active = 1;
            push_run();
        end
        @(negedge clk);
        e = exp_ctrl(cyc - base, active);
        check("ctrl_relu", {st0, busy0, done0, yv0, ba0, wa0, xa0}, e);
        check("ctrl_lin",  {st1, busy1, done1, yv1, ba1, wa1, xa1}, e);
        if (yv0) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL y_relu_unexpected: got idx %0d data %0h expected no output", yi0, yd0);
            end else begin
                q = exp_q.pop_front();
                check("y_relu", {yi0, yd0}, q);
            end
        end
        if (yv1) begin
            if (exp_lin_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL y_lin_unexpected: got idx %0d data %0h expected no output", yi1, yd1);
            end else begin
                q = exp_lin_q.pop_front();
                check("y_lin", {yi1, yd1}, q);
            end
        end
    endtask

    task automatic fill_table(input vec_t v);
        logic [15:0] b;
        b = v.bias_base;
        for (int n = 0; n < 16; n++) begin
            bias_mem[n] = b;
            b = b + v.bias_step;
            x_mem[n] = v.x_val;
        end
        for (int i = 0; i < 256; i++) w_mem[i] = v.w_val;
    endtask

    task automatic fill_random();
        for (int n = 0; n < 16; n++) begin
            bias_mem[n] = 16'($urandom_range(0, 4095)) - 16'd2048;
            x_mem[n]    = 16'($urandom_range(0, 2047)) - 16'd1024;
        end
        for (int i = 0; i < 256; i++) w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    endtask

    task automatic run_one();
        start = 1;
        tick();
        start = 0;
        repeat (185) tick();
        check("queue_relu_empty", 64'(exp_q.size()), 64'd0);
        check("queue_lin_empty", 64'(exp_lin_q.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_relu"}, {st0, busy0, done0, yv0, ba0, wa0, xa0, yi0, yd0}, 64'd0);
        check({tag, "_lin"},  {st1, busy1, done1, yv1, ba1, wa1, xa1, yi1, yd1}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0080, 16'h0100, 16'h0800, 16'h0000, 16'h0800, 16'h0000};
        vecs[2] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
        vecs[3] = '{16'h0000, 16'h0000, 16'h8001, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
        vecs[4] = '{16'h0000, 16'hFF00, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'hFF00};
        vecs[5] = '{16'h0040, 16'h0000, 16'hFF80, 16'hFFF0, 16'h00C0, 16'h0000, 16'h00C0, 16'h0000};

        // reset
        reset = 1;
        start = 0;
        use_table = 1;
        cur = vecs[0];
        fill_table(vecs[0]);
        repeat (3) tick();
        check_zero_outputs("reset_state");
        reset = 0;
        repeat (2) tick();

        // table-driven runs
        for (int v = 0; v < 6; v++) begin
            cur = vecs[v];
            fill_table(vecs[v]);
            run_one();
        end

        // start pulses while busy and during DONE are ignored
        cur = vecs[1];
        fill_table(vecs[1]);
        start = 1;
        tick();
        for (int k = 1; k < 190; k++) begin
            start = (k == 5 || k == 40 || k == 100 || k == 150 || k == 181);
            tick();
        end
        start = 0;
        check("pulse_queue_empty", 64'(exp_q.size()), 64'd0);

        // start held through DONE restarts from the following IDLE cycle
        start = 1;
        repeat (183) tick();
        start = 0;
        repeat (185) tick();
        check("held_queue_empty", 64'(exp_q.size() + exp_lin_q.size()), 64'd0);

        // random data, clean run
        use_table = 0;
        fill_random();
        run_one();

        // reset in neuron 2 MAC abandons the run
        start = 1;
        tick();
        start = 0;
        repeat (40) tick();
        check("pre_reset_state", 64'(st0), 64'(S_MAC));
        reset = 1;
        #1;
        check_zero_outputs("async_reset");
        active = 0;
        exp_q.delete();
        exp_lin_q.delete();
        repeat (3) tick();
        reset = 0;
        repeat (40) tick();
        run_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
